// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM command sequencer:
// FSM encoding, command bundle layout and controller latencies.
package psram_pkg;

    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 16;
    localparam int CMD_W     = 40;
    localparam int WR_CYCLES = 8;
    localparam int RD_CYCLES = 8;

    typedef enum logic [2:0] {
        GUARD,
        IDLE,
        ISSUE,
        WAIT_WR,
        WAIT_RD
    } state_e;

    typedef struct packed {
        logic              write;
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/psram_cmd_fifo.sv
// Synchronous command FIFO with occupancy count.
// Push and pop may happen in the same cycle; no write-through bypass.
module psram_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = psram_pkg::CMD_W,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/psram_cmd_sequencer.sv
// Paces queued read/write commands into a PSRAM controller that has
// no busy output, and returns read data or timeout responses.
module psram_cmd_sequencer #(
    parameter int DEPTH        = 4,
    parameter int WR_CYCLES    = psram_pkg::WR_CYCLES,
    parameter int RD_TIMEOUT   = 2 * psram_pkg::RD_CYCLES,
    parameter int GUARD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_bank,
    input  logic [21:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rd_timeout_err,
    output logic        busy,
    output logic        mem_bank_sel,
    output logic [21:0] mem_addr,
    output logic        mem_write_en,
    output logic [15:0] mem_data_in,
    output logic        mem_read_en,
    input  logic        mem_read_avail,
    input  logic [15:0] mem_data_out
);

    import psram_pkg::*;

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAX_A = (RD_TIMEOUT > GUARD_CYCLES) ? RD_TIMEOUT : GUARD_CYCLES;
    localparam int MAX_C = (MAX_A > WR_CYCLES) ? MAX_A : WR_CYCLES;
    localparam int CNT_W = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYCLES - 2);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_TIMEOUT - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bank_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              wen_q;
    logic              ren_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              err_q;

    cmd_t          push_cmd;
    cmd_t          head_cmd;
    logic          full;
    logic          empty;
    logic          pop;
    logic [CW-1:0] count;

    assign push_cmd = '{
        write: cmd_write,
        bank:  cmd_bank,
        addr:  cmd_addr,
        wdata: cmd_wdata
    };

    assign pop = (state_q == IDLE) && !empty;

    psram_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .wdata_i (push_cmd),
        .rdata_o (head_cmd),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Controller keeps running through our reset, so GUARD holds off issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GUARD;
            cnt_q       <= '0;
            bank_q      <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                GUARD: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == GUARD_LAST) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!empty) begin
                        bank_q  <= head_cmd.bank;
                        addr_q  <= head_cmd.addr;
                        din_q   <= head_cmd.wdata;
                        wen_q   <= head_cmd.write;
                        ren_q   <= !head_cmd.write;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wen_q   <= 1'b0;
                    ren_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= wen_q ? WAIT_WR : WAIT_RD;
                end
                WAIT_WR: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == WR_LAST) begin
                        state_q <= IDLE;
                    end
                end
                WAIT_RD: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_read_avail) begin
                        rsp_rdata_q <= mem_data_out;
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (cnt_q == RD_LAST) begin
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= GUARD;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= GUARD;
                end
            endcase
        end
    end

    assign cmd_ready      = !full;
    assign busy           = (state_q != IDLE) || (count != '0);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rd_timeout_err = err_q;
    assign mem_bank_sel   = bank_q;
    assign mem_addr       = addr_q;
    assign mem_data_in    = din_q;
    assign mem_write_en   = wen_q;
    assign mem_read_en    = ren_q;

endmodule
